gshare_predictor: RTL and testbench

GSHARE_PREDICTOR -- requirements
Module: gshare_predictor

---
 rtl/gshare_predictor.sv | 163 ++++++++++++++++
 tb/tb_gshare_predictor.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/gshare_predictor.sv
// Gshare/bimodal branch direction predictor with a pending-branch table that
// trains 2-bit PHT counters from CDB results and repairs the GHR on mispredicts.
module gshare_predictor #(
  parameter int PHT_IDX_W = 6,
  parameter int HIST_W    = 6,
  parameter int DEPTH     = 16,
  parameter int TAG_W     = 4,
  parameter int MODE      = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rdy,
  input  logic [31:0]          query_pc,
  output logic                 jump,
  input  logic                 alloc_valid,
  input  logic [TAG_W-1:0]     alloc_tag,
  input  logic [TAG_W+32:0]    cdb,
  input  logic                 flush,
  output logic                 full,
  output logic                 mispredict,
  output logic [TAG_W-1:0]     mispredict_tag
);

  localparam int PHT_N  = 1 << PHT_IDX_W;
  localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]           pht_q  [PHT_N];
  logic [1:0]           pht_d  [PHT_N];
  logic [HIST_W-1:0]    ghr_q, ghr_d;
  logic [DEPTH-1:0]     busy_q, busy_d;
  logic [DEPTH-1:0]     pred_q, pred_d;
  logic [TAG_W-1:0]     tag_q  [DEPTH];
  logic [TAG_W-1:0]     tag_d  [DEPTH];
  logic [PHT_IDX_W-1:0] idx_q  [DEPTH];
  logic [PHT_IDX_W-1:0] idx_d  [DEPTH];
  logic [HIST_W-1:0]    snap_q [DEPTH];
  logic [HIST_W-1:0]    snap_d [DEPTH];
  logic                 mispredict_q, mispredict_d;
  logic [TAG_W-1:0]     mtag_q, mtag_d;

  logic [PHT_IDX_W-1:0] ghr_ext, lookup_idx;
  logic                 cdb_valid, cdb_taken;
  logic [TAG_W-1:0]     cdb_tag;
  logic [SLOT_W-1:0]    free_idx, res_idx;
  logic                 res_hit;
  logic [HIST_W-1:0]    res_snap;
  logic                 res_pred;
  logic [PHT_IDX_W-1:0] res_pidx;
  logic [1:0]           res_ctr, res_ctr_upd;
  logic [HIST_W-1:0]    ghr_alloc, ghr_restore;
  logic                 unused_pc_bits;

  assign ghr_ext    = PHT_IDX_W'(ghr_q);
  assign lookup_idx = query_pc[PHT_IDX_W+1:2] ^ ((MODE == 1) ? ghr_ext : '0);
  assign jump       = pht_q[lookup_idx][1];
  assign full       = &busy_q;

  assign unused_pc_bits = ^{query_pc[31:PHT_IDX_W+2], query_pc[1:0]};

  assign cdb_valid = cdb[TAG_W+32];
  assign cdb_tag   = cdb[TAG_W+31:32];
  assign cdb_taken = |cdb[31:0];

  // Descending scan so the lowest matching index is the one that sticks.
  always_comb begin
    free_idx = '0;
    res_idx  = '0;
    res_hit  = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!busy_q[i]) free_idx = SLOT_W'(i);
      if (cdb_valid && busy_q[i] && (tag_q[i] == cdb_tag)) begin
        res_hit = 1'b1;
        res_idx = SLOT_W'(i);
      end
    end
  end

  assign res_snap = snap_q[res_idx];
  assign res_pred = pred_q[res_idx];
  assign res_pidx = idx_q[res_idx];
  assign res_ctr  = pht_q[res_pidx];

  always_comb begin
    res_ctr_upd = res_ctr;
    if (cdb_taken) begin
      if (res_ctr != 2'b11) res_ctr_upd = res_ctr + 2'd1;
    end else begin
      if (res_ctr != 2'b00) res_ctr_upd = res_ctr - 2'd1;
    end
  end

  if (HIST_W > 1) begin : g_hist_shift
    assign ghr_alloc   = {ghr_q[HIST_W-2:0], jump};
    assign ghr_restore = {res_snap[HIST_W-2:0], cdb_taken};
  end else begin : g_hist_bit
    assign ghr_alloc   = jump;
    assign ghr_restore = cdb_taken;
  end

  always_comb begin
    pht_d        = pht_q;
    ghr_d        = ghr_q;
    busy_d       = busy_q;
    pred_d       = pred_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    snap_d       = snap_q;
    mispredict_d = mispredict_q;
    mtag_d       = mtag_q;
    if (rdy) begin
      mispredict_d = 1'b0;
      if (alloc_valid && !full && !flush) begin
        busy_d[free_idx] = 1'b1;
        pred_d[free_idx] = jump;
        tag_d[free_idx]  = alloc_tag;
        idx_d[free_idx]  = lookup_idx;
        snap_d[free_idx] = ghr_q;
        ghr_d            = ghr_alloc;
      end
      if (res_hit) begin
        busy_d[res_idx] = 1'b0;
        pht_d[res_pidx] = res_ctr_upd;
        if (cdb_taken != res_pred) begin
          mispredict_d = 1'b1;
          mtag_d       = tag_q[res_idx];
          // Restore overrides the allocation shift; a flush keeps the GHR as is.
          if (!flush) ghr_d = ghr_restore;
        end
      end
      if (flush) busy_d = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < PHT_N; i++) pht_q[i] <= 2'b01;
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= '0;
        idx_q[i]  <= '0;
        snap_q[i] <= '0;
      end
      ghr_q        <= '0;
      busy_q       <= '0;
      pred_q       <= '0;
      mispredict_q <= 1'b0;
      mtag_q       <= '0;
    end else begin
      pht_q        <= pht_d;
      ghr_q        <= ghr_d;
      busy_q       <= busy_d;
      pred_q       <= pred_d;
      tag_q        <= tag_d;
      idx_q        <= idx_d;
      snap_q       <= snap_d;
      mispredict_q <= mispredict_d;
      mtag_q       <= mtag_d;
    end
  end

  assign mispredict     = mispredict_q;
  assign mispredict_tag = mtag_q;

endmodule

// File: tb/tb_gshare_predictor.sv
// Directed bench for gshare_predictor: a gshare instance and a bimodal instance
// share stimulus; each scenario task checks its own hand-computed expectations.
module tb_gshare_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [31:0] query_pc;
  logic        alloc_valid;
  logic [3:0]  alloc_tag;
  logic [36:0] cdb;
  logic        flush;

  logic        jump, full, mispredict;
  logic [3:0]  mispredict_tag;
  logic        jump_bi, full_bi, mispredict_bi;
  logic [3:0]  mispredict_tag_bi;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  gshare_predictor #(.PHT_IDX_W(6), .HIST_W(6), .DEPTH(16), .TAG_W(4), .MODE(1)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .query_pc(query_pc), .jump(jump),
    .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .cdb(cdb), .flush(flush),
    .full(full), .mispredict(mispredict), .mispredict_tag(mispredict_tag)
  );

  gshare_predictor #(.PHT_IDX_W(6), .HIST_W(6), .DEPTH(16), .TAG_W(4), .MODE(0)) dut_bi (
    .clk(clk), .rst(rst), .rdy(rdy), .query_pc(query_pc), .jump(jump_bi),
    .alloc_valid(alloc_valid), .alloc_tag(alloc_tag), .cdb(cdb), .flush(flush),
    .full(full_bi), .mispredict(mispredict_bi), .mispredict_tag(mispredict_tag_bi)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One clock of stimulus; inputs return to idle afterwards (rdy is left alone).
  task automatic drive(input logic av, input logic [3:0] at, input logic cv,
                       input logic [3:0] ct, input logic [31:0] val, input logic fl);
    alloc_valid = av;
    alloc_tag   = at;
    cdb         = {cv, ct, val};
    flush       = fl;
    step();
    alloc_valid = 1'b0;
    alloc_tag   = 4'd0;
    cdb         = '0;
    flush       = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1; rdy = 1'b1; query_pc = 32'd0;
    alloc_valid = 1'b0; alloc_tag = 4'd0; cdb = '0; flush = 1'b0;
    repeat (2) step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    query_pc = 32'h100;
    #1;
    total++; if (jump !== 1'b0) $display("FAIL reset_jump: got %0b expected 0", jump); else passed++;
    total++; if (full !== 1'b0) $display("FAIL reset_full: got %0b expected 0", full); else passed++;
    total++; if (mispredict !== 1'b0) $display("FAIL reset_mispredict: got %0b expected 0", mispredict); else passed++;
    total++; if (mispredict_tag !== 4'd0) $display("FAIL reset_mtag: got %0h expected 0", mispredict_tag); else passed++;
    total++; if (dut.ghr_q !== 6'd0) $display("FAIL reset_ghr: got %0h expected 0", dut.ghr_q); else passed++;
    total++; if (dut.pht_q[0] !== 2'b01) $display("FAIL reset_pht0: got %0b expected 01", dut.pht_q[0]); else passed++;
    total++; if (dut.pht_q[63] !== 2'b01) $display("FAIL reset_pht63: got %0b expected 01", dut.pht_q[63]); else passed++;
  endtask

  task automatic test_basic_mispredict();
    do_reset();
    query_pc = 32'h100;
    #1;
    total++; if (jump !== 1'b0) $display("FAIL basic_jump: got %0b expected 0", jump); else passed++;
    drive(1'b1, 4'd3, 1'b0, 4'd0, 32'd0, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 4'd3, 32'd1, 1'b0);
    total++; if (mispredict !== 1'b1) $display("FAIL basic_mispredict: got %0b expected 1", mispredict); else passed++;
    total++; if (mispredict_tag !== 4'd3) $display("FAIL basic_mtag: got %0h expected 3", mispredict_tag); else passed++;
    total++; if (dut.pht_q[0] !== 2'b10) $display("FAIL basic_ctr: got %0b expected 10", dut.pht_q[0]); else passed++;
    total++; if (dut.ghr_q !== 6'd1) $display("FAIL basic_ghr: got %0h expected 1", dut.ghr_q); else passed++;
    drive(1'b0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    total++; if (mispredict !== 1'b0) $display("FAIL basic_pulse_end: got %0b expected 0", mispredict); else passed++;
    total++; if (mispredict_tag !== 4'd3) $display("FAIL basic_mtag_hold: got %0h expected 3", mispredict_tag); else passed++;
  endtask

  task automatic test_bimodal_training();
    do_reset();
    query_pc = 32'h104;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 4'd1, 1'b0, 4'd0, 32'd0, 1'b0);
      drive(1'b0, 4'd0, 1'b1, 4'd1, 32'd1, 1'b0);
      if (i == 0) begin
        total++; if (mispredict_bi !== 1'b1) $display("FAIL bi_first_mispredict: got %0b expected 1", mispredict_bi); else passed++;
      end
    end
    total++; if (dut_bi.pht_q[1] !== 2'b11) $display("FAIL bi_ctr_after3: got %0b expected 11", dut_bi.pht_q[1]); else passed++;
    total++; if (jump_bi !== 1'b1) $display("FAIL bi_jump_after3: got %0b expected 1", jump_bi); else passed++;
    drive(1'b1, 4'd1, 1'b0, 4'd0, 32'd0, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 4'd1, 32'h8000_0000, 1'b0);
    total++; if (dut_bi.pht_q[1] !== 2'b11) $display("FAIL bi_ctr_saturate: got %0b expected 11", dut_bi.pht_q[1]); else passed++;
    total++; if (mispredict_bi !== 1'b0) $display("FAIL bi_correct_pred: got %0b expected 0", mispredict_bi); else passed++;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 4'd2, 1'b0, 4'd0, 32'd0, 1'b0);
      drive(1'b0, 4'd0, 1'b1, 4'd2, 32'd0, 1'b0);
    end
    total++; if (dut_bi.pht_q[1] !== 2'b00) $display("FAIL bi_ctr_floor: got %0b expected 00", dut_bi.pht_q[1]); else passed++;
    total++; if (jump_bi !== 1'b0) $display("FAIL bi_jump_floor: got %0b expected 0", jump_bi); else passed++;
  endtask

  task automatic test_full_reuse();
    do_reset();
    query_pc = 32'h0;
    for (int i = 0; i < 16; i++) drive(1'b1, 4'(i), 1'b0, 4'd0, 32'd0, 1'b0);
    total++; if (full !== 1'b1) $display("FAIL full_after16: got %0b expected 1", full); else passed++;
    drive(1'b1, 4'd7, 1'b0, 4'd0, 32'd0, 1'b0);
    total++; if (full !== 1'b1) $display("FAIL full_after17: got %0b expected 1", full); else passed++;
    total++; if (dut.tag_q[7] !== 4'd7) $display("FAIL full_tag7_kept: got %0h expected 7", dut.tag_q[7]); else passed++;
    drive(1'b1, 4'hA, 1'b1, 4'd5, 32'd0, 1'b0);
    total++; if (full !== 1'b0) $display("FAIL reuse_full_drop: got %0b expected 0", full); else passed++;
    total++; if (dut.busy_q !== 16'hFFDF) $display("FAIL reuse_busy: got %0h expected ffdf", dut.busy_q); else passed++;
    total++; if (mispredict !== 1'b0) $display("FAIL reuse_no_mispredict: got %0b expected 0", mispredict); else passed++;
    drive(1'b1, 4'hA, 1'b0, 4'd0, 32'd0, 1'b0);
    total++; if (full !== 1'b1) $display("FAIL reuse_refull: got %0b expected 1", full); else passed++;
    total++; if (dut.tag_q[5] !== 4'hA) $display("FAIL reuse_slot5_tag: got %0h expected a", dut.tag_q[5]); else passed++;
  endtask

  task automatic test_ghr_restore();
    do_reset();
    query_pc = 32'h0;
    drive(1'b1, 4'd1, 1'b0, 4'd0, 32'd0, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 4'd1, 32'd1, 1'b0);
    drive(1'b1, 4'd2, 1'b0, 4'd0, 32'd0, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 4'd2, 32'd1, 1'b0);
    total++; if (dut.ghr_q !== 6'b000011) $display("FAIL restore_setup_ghr: got %0h expected 3", dut.ghr_q); else passed++;
    drive(1'b1, 4'd4, 1'b0, 4'd0, 32'd0, 1'b0);
    drive(1'b1, 4'd5, 1'b0, 4'd0, 32'd0, 1'b0);
    total++; if (dut.ghr_q !== 6'b001100) $display("FAIL restore_pre_ghr: got %0h expected c", dut.ghr_q); else passed++;
    drive(1'b1, 4'd6, 1'b1, 4'd4, 32'd1, 1'b0);
    total++; if (dut.ghr_q !== 6'b000111) $display("FAIL restore_ghr: got %0h expected 7", dut.ghr_q); else passed++;
    total++; if (mispredict !== 1'b1) $display("FAIL restore_mispredict: got %0b expected 1", mispredict); else passed++;
    total++; if (mispredict_tag !== 4'd4) $display("FAIL restore_mtag: got %0h expected 4", mispredict_tag); else passed++;
    total++; if (dut.pht_q[3] !== 2'b10) $display("FAIL restore_ctr3: got %0b expected 10", dut.pht_q[3]); else passed++;
    drive(1'b0, 4'd0, 1'b1, 4'd5, 32'd0, 1'b0);
    total++; if (mispredict !== 1'b0) $display("FAIL restore_younger_ok: got %0b expected 0", mispredict); else passed++;
    total++; if (dut.ghr_q !== 6'b000111) $display("FAIL restore_ghr_kept: got %0h expected 7", dut.ghr_q); else passed++;
    total++; if (dut.pht_q[6] !== 2'b00) $display("FAIL restore_ctr6: got %0b expected 00", dut.pht_q[6]); else passed++;
  endtask

  task automatic test_flush();
    do_reset();
    query_pc = 32'h0;
    drive(1'b1, 4'd1, 1'b0, 4'd0, 32'd0, 1'b0);
    drive(1'b1, 4'd2, 1'b0, 4'd0, 32'd0, 1'b0);
    drive(1'b1, 4'd3, 1'b0, 4'd0, 32'd0, 1'b0);
    drive(1'b1, 4'd4, 1'b0, 4'd0, 32'd0, 1'b1);
    total++; if (full !== 1'b0) $display("FAIL flush_full: got %0b expected 0", full); else passed++;
    total++; if (dut.busy_q !== 16'h0000) $display("FAIL flush_busy: got %0h expected 0", dut.busy_q); else passed++;
    drive(1'b0, 4'd0, 1'b1, 4'd1, 32'd1, 1'b0);
    total++; if (mispredict !== 1'b0) $display("FAIL flush_stale_cdb: got %0b expected 0", mispredict); else passed++;
    total++; if (dut.pht_q[0] !== 2'b01) $display("FAIL flush_pht: got %0b expected 01", dut.pht_q[0]); else passed++;
    total++; if (dut.ghr_q !== 6'd0) $display("FAIL flush_ghr: got %0h expected 0", dut.ghr_q); else passed++;
  endtask

  task automatic test_rdy_and_reset();
    do_reset();
    query_pc = 32'h0;
    drive(1'b1, 4'd3, 1'b0, 4'd0, 32'd0, 1'b0);
    drive(1'b1, 4'd7, 1'b0, 4'd0, 32'd0, 1'b0);
    drive(1'b0, 4'd0, 1'b1, 4'd3, 32'd1, 1'b0);
    total++; if (mispredict !== 1'b1) $display("FAIL rdy_setup_mispredict: got %0b expected 1", mispredict); else passed++;
    rdy = 1'b0;
    cdb = {1'b1, 4'd7, 32'd1};
    repeat (4) step();
    total++; if (mispredict !== 1'b1) $display("FAIL rdy_hold_mispredict: got %0b expected 1", mispredict); else passed++;
    total++; if (dut.busy_q !== 16'h0002) $display("FAIL rdy_hold_busy: got %0h expected 2", dut.busy_q); else passed++;
    total++; if (dut.pht_q[0] !== 2'b10) $display("FAIL rdy_hold_pht: got %0b expected 10", dut.pht_q[0]); else passed++;
    total++; if (dut.ghr_q !== 6'd1) $display("FAIL rdy_hold_ghr: got %0h expected 1", dut.ghr_q); else passed++;
    rdy = 1'b1;
    cdb = '0;
    rst = 1'b1;
    #2;
    total++; if (dut.pht_q[0] !== 2'b01) $display("FAIL arst_pht: got %0b expected 01", dut.pht_q[0]); else passed++;
    total++; if (dut.ghr_q !== 6'd0) $display("FAIL arst_ghr: got %0h expected 0", dut.ghr_q); else passed++;
    total++; if (dut.busy_q !== 16'h0000) $display("FAIL arst_busy: got %0h expected 0", dut.busy_q); else passed++;
    total++; if (mispredict !== 1'b0) $display("FAIL arst_mispredict: got %0b expected 0", mispredict); else passed++;
    step();
    rst = 1'b0;
    drive(1'b0, 4'd0, 1'b1, 4'd7, 32'd1, 1'b0);
    total++; if (mispredict !== 1'b0) $display("FAIL arst_dropped_entry: got %0b expected 0", mispredict); else passed++;
  endtask

  initial begin
    test_reset();
    test_basic_mispredict();
    test_bimodal_training();
    test_full_reuse();
    test_ghr_restore();
    test_flush();
    test_rdy_and_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
